md_reservation_station: RTL and testbench

//  Reservation station feeding the multiply/divide functional unit (Tomasulo core).
//  - Buffers issued mul/div ops until both operands are present, snooping the CDB for pending tags.
//  - Dispatches one ready op at a time: start pulse plus stable operands, RS number and ROB tag.
//  - Holds the unit busy until its done handshake, then frees the entry.

---
 rtl/md_reservation_station.sv | 189 ++++++++++++++++++
 tb/tb_md_reservation_station.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_reservation_station.sv
// Multiply/divide reservation station: buffers issued ops, snoops the CDB, and dispatches one
// ready op at a time over a start/done handshake. Define RS_STATS_EN for dispatch/stall counters.
module md_reservation_station #(
    parameter int               ENTRIES = 4,
    parameter int               DATA_W  = 32,
    parameter int               TAG_W   = 5,
    parameter logic [TAG_W-1:0] RS_BASE = TAG_W'(8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_ctrl,
    input  logic [TAG_W-1:0]  issue_rd_rob,
    input  logic              issue_qj_v,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic              issue_qk_v,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              fu_data_ready,
    output logic [DATA_W-1:0] fu_x,
    output logic [DATA_W-1:0] fu_y,
    output logic [3:0]        fu_ctrl,
    output logic [TAG_W-1:0]  fu_save_no,
    output logic [TAG_W-1:0]  fu_rd_rob,
    input  logic              fu_done,
    output logic [15:0]       stat_dispatch,
    output logic [15:0]       stat_stall
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t             state;
    logic [ENTRIES-1:0] valid, disp, qj_v, qk_v;
    logic [ENTRIES-1:0] ready, wake_j, wake_k;
    logic [TAG_W-1:0]   qj [ENTRIES];
    logic [TAG_W-1:0]   qk [ENTRIES];
    logic [DATA_W-1:0]  vj [ENTRIES];
    logic [DATA_W-1:0]  vk [ENTRIES];
    logic [3:0]         ctrl [ENTRIES];
    logic [TAG_W-1:0]   rd_rob [ENTRIES];
    logic               free_found, ready_found, seen_low;
    logic [IDX_W-1:0]   free_idx, sel_idx, cur_idx;
    logic               issue_fire, byp_j, byp_k, dispatch, complete;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wake_j = '0;
        wake_k = '0;
        ready  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            wake_j[i] = cdb_valid && valid[i] && qj_v[i] && (qj[i] == cdb_tag);
            wake_k[i] = cdb_valid && valid[i] && qk_v[i] && (qk[i] == cdb_tag);
            ready[i]  = valid[i] && !qj_v[i] && !qk_v[i] && !disp[i];
        end
    end

    // Descending scan so the lowest index wins for both allocation and selection.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        sel_idx     = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                ready_found = 1'b1;
                sel_idx     = IDX_W'(i);
            end
        end
    end

    assign issue_ready = free_found;
    assign issue_fire  = issue_valid && free_found && !flush;
    assign byp_j       = cdb_valid && issue_qj_v && (issue_qj == cdb_tag);
    assign byp_k       = cdb_valid && issue_qk_v && (issue_qk == cdb_tag);
    assign dispatch    = (state == IDLE) && ready_found;
    assign complete    = (state == WAIT) && fu_done && seen_low;

    // NOTE: the payload array has no reset; only the valid/pending flags decide whether it is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (wake_j[i]) vj[i] <= cdb_data;
            if (wake_k[i]) vk[i] <= cdb_data;
        end
        if (issue_fire) begin
            vj[free_idx]     <= byp_j ? cdb_data : issue_vj;
            vk[free_idx]     <= byp_k ? cdb_data : issue_vk;
            qj[free_idx]     <= issue_qj;
            qk[free_idx]     <= issue_qk;
            ctrl[free_idx]   <= issue_ctrl;
            rd_rob[free_idx] <= issue_rd_rob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
            disp  <= '0;
            qj_v  <= '0;
            qk_v  <= '0;
        end else begin
            qj_v <= qj_v & ~wake_j;
            qk_v <= qk_v & ~wake_k;
            if (dispatch) disp[sel_idx] <= 1'b1;
            if (complete) begin
                valid[cur_idx] <= 1'b0;
                disp[cur_idx]  <= 1'b0;
            end
            // Issue only targets an invalid entry, so it never collides with wake/complete above.
            if (issue_fire) begin
                valid[free_idx] <= 1'b1;
                disp[free_idx]  <= 1'b0;
                qj_v[free_idx]  <= issue_qj_v && !byp_j;
                qk_v[free_idx]  <= issue_qk_v && !byp_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state         <= IDLE;
            cur_idx       <= '0;
            seen_low      <= 1'b0;
            fu_data_ready <= 1'b0;
            fu_x          <= '0;
            fu_y          <= '0;
            fu_ctrl       <= '0;
            fu_save_no    <= '0;
            fu_rd_rob     <= '0;
        end else begin
            case (state)
                IDLE: if (ready_found) begin
                    cur_idx       <= sel_idx;
                    seen_low      <= 1'b0;
                    fu_data_ready <= 1'b1;
                    fu_x          <= vj[sel_idx];
                    fu_y          <= vk[sel_idx];
                    fu_ctrl       <= ctrl[sel_idx];
                    fu_save_no    <= RS_BASE + TAG_W'(sel_idx);
                    fu_rd_rob     <= rd_rob[sel_idx];
                    state         <= START;
                end
                START: begin
                    fu_data_ready <= 1'b0;
                    state         <= WAIT;
                end
                // A done level still high from the previous op is ignored until it has dropped.
                WAIT: if (fu_done && seen_low) begin
                    fu_data_ready <= 1'b0;
                    state         <= IDLE;
                end else if (!fu_done) begin
                    seen_low <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_STATS_EN
    logic [15:0] disp_cnt, stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (dispatch && !flush) disp_cnt <= disp_cnt + 16'd1;
            if (ready_found && state != IDLE) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stat_dispatch = disp_cnt;
    assign stat_stall    = stall_cnt;
`else
    assign stat_dispatch = '0;
    assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_md_reservation_station.sv
// Directed and randomized bench for md_reservation_station; random phase is checked against a
// slot-level model of the station and the functional unit it drives.
`timescale 1ns/1ps
module tb_md_reservation_station;
    localparam int               ENTRIES = 4;
    localparam int               DATA_W  = 32;
    localparam int               TAG_W   = 5;
    localparam logic [TAG_W-1:0] RS_BASE = 5'd8;

    logic              clk = 1'b0;
    logic              rst, flush, issue_valid, issue_ready;
    logic [3:0]        issue_ctrl;
    logic [TAG_W-1:0]  issue_rd_rob, issue_qj, issue_qk, cdb_tag;
    logic              issue_qj_v, issue_qk_v, cdb_valid;
    logic [DATA_W-1:0] issue_vj, issue_vk, cdb_data;
    logic              fu_data_ready, fu_done;
    logic [DATA_W-1:0] fu_x, fu_y;
    logic [3:0]        fu_ctrl;
    logic [TAG_W-1:0]  fu_save_no, fu_rd_rob;
    logic [15:0]       stat_dispatch, stat_stall;

    always #5 clk = ~clk;

    md_reservation_station #(
        .ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .RS_BASE(RS_BASE)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
        .issue_rd_rob(issue_rd_rob), .issue_qj_v(issue_qj_v), .issue_qj(issue_qj),
        .issue_vj(issue_vj), .issue_qk_v(issue_qk_v), .issue_qk(issue_qk), .issue_vk(issue_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_data_ready(fu_data_ready), .fu_x(fu_x), .fu_y(fu_y), .fu_ctrl(fu_ctrl),
        .fu_save_no(fu_save_no), .fu_rd_rob(fu_rd_rob), .fu_done(fu_done),
        .stat_dispatch(stat_dispatch), .stat_stall(stat_stall)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [3:0] c, input logic [4:0] rob,
                             input logic aj_v, input logic [4:0] aj, input logic [31:0] av,
                             input logic bk_v, input logic [4:0] bk, input logic [31:0] bv);
        issue_valid  = 1'b1;
        issue_ctrl   = c;
        issue_rd_rob = rob;
        issue_qj_v   = aj_v;
        issue_qj     = aj;
        issue_vj     = av;
        issue_qk_v   = bk_v;
        issue_qk     = bk;
        issue_vk     = bv;
    endtask

    task automatic expect_start(input string tag, input logic [31:0] x, input logic [31:0] y,
                                input logic [3:0] c, input logic [4:0] s, input logic [4:0] r);
        check({tag, "_start"}, fu_data_ready, 1'b1);
        check({tag, "_x"}, fu_x, x);
        check({tag, "_y"}, fu_y, y);
        check({tag, "_ctrl"}, fu_ctrl, c);
        check({tag, "_save_no"}, fu_save_no, s);
        check({tag, "_rd_rob"}, fu_rd_rob, r);
    endtask

    // Called right after a start pulse is observed: done low for two cycles, then high once.
    task automatic complete_op();
        fu_done = 1'b0;
        tick();
        check("pulse_one_cycle", fu_data_ready, 1'b0);
        tick();
        fu_done = 1'b1;
        tick();
        fu_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; cdb_valid = 1'b0; fu_done = 1'b0;
        issue_ctrl = '0; issue_rd_rob = '0; issue_qj_v = 1'b0; issue_qj = '0; issue_vj = '0;
        issue_qk_v = 1'b0; issue_qk = '0; issue_vk = '0; cdb_tag = '0; cdb_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Slot-level model for the random phase.
    bit          m_used [ENTRIES];
    bit          m_pa [ENTRIES];
    bit          m_pb [ENTRIES];
    bit          m_dsp [ENTRIES];
    int          m_ta [ENTRIES];
    int          m_tb [ENTRIES];
    logic [31:0] m_va [ENTRIES];
    logic [31:0] m_vb [ENTRIES];
    logic [3:0]  m_ctl [ENTRIES];
    logic [4:0]  m_rob [ENTRIES];
    bit          m_busy, complete_now, exp_start;
    int          m_cur, u_state, u_low, exp_slot, free_slot, n_free, exp_disp, exp_stall;

    initial begin
        do_reset();
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_start", fu_data_ready, 1'b0);
        check("rst_fu_x", fu_x, 32'd0);
        check("rst_save_no", fu_save_no, 5'd0);
        check("rst_stat_dispatch", stat_dispatch, 16'd0);
        check("rst_stat_stall", stat_stall, 16'd0);

        // Both operands ready: start two cycles after issue.
        set_issue(4'b0010, 5'd1, 1'b0, 5'd0, 32'd7, 1'b0, 5'd0, 32'd6);
        tick();
        issue_valid = 1'b0;
        check("t1_no_early_start", fu_data_ready, 1'b0);
        tick();
        expect_start("t1", 32'd7, 32'd6, 4'b0010, 5'd8, 5'd1);
        complete_op();
        check("t1_issue_ready", issue_ready, 1'b1);

        // B pending on tag 3; unrelated tag 4 first, then tag 3 wakes it.
        set_issue(4'b0011, 5'd2, 1'b0, 5'd0, 32'd20, 1'b1, 5'd3, 32'd0);
        tick();
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 32'd99;
        tick();
        check("t2_other_tag_pending", fu_data_ready, 1'b0);
        cdb_tag = 5'd3; cdb_data = 32'd5;
        tick();
        cdb_valid = 1'b0;
        check("t2_no_start_before_wake", fu_data_ready, 1'b0);
        tick();
        expect_start("t2", 32'd20, 32'd5, 4'b0011, 5'd8, 5'd2);
        complete_op();

        // Same-cycle bypass of A.
        set_issue(4'b0010, 5'd3, 1'b1, 5'd3, 32'd0, 1'b0, 5'd0, 32'd2);
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'd9;
        tick();
        issue_valid = 1'b0; cdb_valid = 1'b0;
        tick();
        expect_start("t3", 32'd9, 32'd2, 4'b0010, 5'd8, 5'd3);
        complete_op();

        // Done stuck high from the previous op must not complete the new one.
        fu_done = 1'b1;
        set_issue(4'b0010, 5'd5, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd2);
        tick();
        set_issue(4'b0011, 5'd6, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0, 32'd4);
        tick();
        issue_valid = 1'b0;
        expect_start("t5a", 32'd1, 32'd2, 4'b0010, 5'd8, 5'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_stale_done_held", fu_data_ready, 1'b0);
        end
        fu_done = 1'b0;
        tick();
        fu_done = 1'b1;
        tick();
        fu_done = 1'b0;
        check("t5_complete_no_start", fu_data_ready, 1'b0);
        tick();
        expect_start("t5b", 32'd3, 32'd4, 4'b0011, 5'd9, 5'd6);
        complete_op();

        // Fill all entries; a fifth request waits and lands in freed entry 0.
        set_issue(4'b0010, 5'd10, 1'b0, 5'd0, 32'd10, 1'b0, 5'd0, 32'd11);
        tick();
        for (int i = 1; i < 4; i++) begin
            set_issue(4'b0010, 5'(10 + i), 1'b0, 5'd0, 32'(20 + i), 1'b1, 5'd7, 32'd0);
            tick();
        end
        check("t4_full", issue_ready, 1'b0);
        set_issue(4'b0011, 5'd14, 1'b0, 5'd0, 32'd50, 1'b0, 5'd0, 32'd51);
        tick();
        check("t4_held_1", issue_ready, 1'b0);
        tick();
        check("t4_held_2", issue_ready, 1'b0);
        fu_done = 1'b1;
        tick();
        fu_done = 1'b0;
        check("t4_freed", issue_ready, 1'b1);
        tick();
        issue_valid = 1'b0;
        check("t4_refilled", issue_ready, 1'b0);
        tick();
        expect_start("t4", 32'd50, 32'd51, 4'b0011, 5'd8, 5'd14);
        complete_op();

        // Wake entries 1..3, dispatch entry 1, then flush in WAIT with a same-cycle issue.
        cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'd77;
        tick();
        cdb_valid = 1'b0;
        check("t6_no_start_on_wake", fu_data_ready, 1'b0);
        tick();
        expect_start("t6", 32'd21, 32'd77, 4'b0010, 5'd9, 5'd11);
        tick();
        tick();
        flush = 1'b1;
        set_issue(4'b0010, 5'd12, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        check("t6_flush_start", fu_data_ready, 1'b0);
        check("t6_flush_x", fu_x, 32'd0);
        check("t6_flush_y", fu_y, 32'd0);
        check("t6_flush_ctrl", fu_ctrl, 4'd0);
        check("t6_flush_save_no", fu_save_no, 5'd0);
        check("t6_flush_rd_rob", fu_rd_rob, 5'd0);
        check("t6_flush_issue_ready", issue_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            fu_done = (i % 2 == 0);
            tick();
            check("t6_after_flush_idle", fu_data_ready, 1'b0);
        end
        fu_done = 1'b0;
`ifdef RS_STATS_EN
        check("t6_stat_dispatch", stat_dispatch, 16'd8);
`else
        check("t6_stat_dispatch", stat_dispatch, 16'd0);
`endif

        // Randomized traffic against the slot model.
        do_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_used[i] = 0; m_pa[i] = 0; m_pb[i] = 0; m_dsp[i] = 0;
        end
        m_busy = 0; m_cur = 0; u_state = 0; u_low = 0; exp_disp = 0; exp_stall = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_ctrl   = $urandom_range(0, 1) ? 4'b0010 : 4'b0011;
            issue_rd_rob = 5'($urandom_range(0, 31));
            issue_qj_v   = 1'($urandom_range(0, 1));
            issue_qj     = 5'($urandom_range(0, 7));
            issue_vj     = $urandom;
            issue_qk_v   = 1'($urandom_range(0, 1));
            issue_qk     = 5'($urandom_range(0, 7));
            issue_vk     = $urandom;
            cdb_valid    = ($urandom_range(0, 2) == 0);
            cdb_tag      = 5'($urandom_range(0, 7));
            cdb_data     = $urandom;
            complete_now = 0;
            case (u_state)
                1: begin
                    fu_done = 1'b0;
                    u_low--;
                    if (u_low == 0) u_state = 2;
                end
                2: begin
                    fu_done = 1'b1;
                    complete_now = 1;
                    u_state = 0;
                end
                default: fu_done = 1'($urandom_range(0, 1));
            endcase

            exp_slot = -1;
            free_slot = -1;
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (m_used[i] && !m_pa[i] && !m_pb[i] && !m_dsp[i]) exp_slot = i;
                if (!m_used[i]) free_slot = i;
            end
            if (m_busy && exp_slot >= 0) exp_stall++;
            exp_start = !m_busy && (exp_slot >= 0);
            if (complete_now) begin
                m_used[m_cur] = 0;
                m_dsp[m_cur] = 0;
                m_busy = 0;
            end
            for (int i = 0; i < ENTRIES; i++) begin
                if (m_used[i] && cdb_valid && m_pa[i] && m_ta[i] == int'(cdb_tag)) begin
                    m_va[i] = cdb_data; m_pa[i] = 0;
                end
                if (m_used[i] && cdb_valid && m_pb[i] && m_tb[i] == int'(cdb_tag)) begin
                    m_vb[i] = cdb_data; m_pb[i] = 0;
                end
            end
            if (issue_valid && free_slot >= 0) begin
                m_used[free_slot] = 1;
                m_dsp[free_slot]  = 0;
                m_ctl[free_slot]  = issue_ctrl;
                m_rob[free_slot]  = issue_rd_rob;
                m_ta[free_slot]   = int'(issue_qj);
                m_tb[free_slot]   = int'(issue_qk);
                m_pa[free_slot]   = issue_qj_v && !(cdb_valid && issue_qj == cdb_tag);
                m_pb[free_slot]   = issue_qk_v && !(cdb_valid && issue_qk == cdb_tag);
                m_va[free_slot]   = (issue_qj_v && cdb_valid && issue_qj == cdb_tag) ? cdb_data : issue_vj;
                m_vb[free_slot]   = (issue_qk_v && cdb_valid && issue_qk == cdb_tag) ? cdb_data : issue_vk;
            end
            if (exp_start) begin
                m_dsp[exp_slot] = 1;
                m_busy = 1;
                m_cur = exp_slot;
                exp_disp++;
                u_state = 1;
                u_low = 2 + int'($urandom_range(0, 2));
            end

            tick();
            n_free = 0;
            for (int i = 0; i < ENTRIES; i++) if (!m_used[i]) n_free++;
            check("rnd_issue_ready", issue_ready, n_free > 0);
            check("rnd_start", fu_data_ready, exp_start);
            if (exp_start) begin
                check("rnd_x", fu_x, m_va[exp_slot]);
                check("rnd_y", fu_y, m_vb[exp_slot]);
                check("rnd_ctrl", fu_ctrl, m_ctl[exp_slot]);
                check("rnd_save_no", fu_save_no, RS_BASE + 5'(exp_slot));
                check("rnd_rd_rob", fu_rd_rob, m_rob[exp_slot]);
            end
        end
        issue_valid = 1'b0; cdb_valid = 1'b0;
`ifdef RS_STATS_EN
        check("rnd_stat_dispatch", stat_dispatch, 16'(exp_disp));
        check("rnd_stat_stall", stat_stall, 16'(exp_stall));
`else
        check("rnd_stat_dispatch", stat_dispatch, 16'd0);
        check("rnd_stat_stall", stat_stall, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
